script_sequencer: RTL and testbench
===================================

# script_sequencer

Parametrised successor to the script analyser: fetches 16-bit script words from the script memory, decodes them and executes action, jump, wait and game-state instructions under a single FSM. Supports single-step and free-running (auto) modes, feedback-conditioned jumps and waits, wait timeouts, and halt/fault states. Sits between the script memory and the traveller target/operate machines in the kitchen controller.

## Interface
Parameters:
- PC_W, 8, program-counter width (byte address)
- PC_STEP, 2, pc increment per instruction
- MS_W, 16, width of the millisecond wait/timeout counter

Ports:
- clk  in  1  system clock
- res  in  1  reset, synchronous, active-high
- instr  in  16  script word at `pc`, valid one cycle after `pc` changes (registered ROM)
- step_pulse  in  1  one-cycle, already-debounced step request
- auto_mode  in  1  1 = run continuously, 0 = one instruction per step_pulse
- ms_tick  in  1  one-cycle strobe every 1 ms
- feedback_sig  in  1  kitchen feedback: action done / condition true
- pc  out  PC_W  current instruction address
- act_cmd  out  5  one-hot pulse {move,get,put,interact,throw}
- act_target  out  5  target machine for move
- game_state  out  8  game state register
- busy  out  1  instruction in progress
- halted  out  1  script ended normally
- fault  out  1  illegal opcode or wait timeout

## Operation
- Fields: i_num=instr[15:8], i_sign=instr[7:5], func=instr[4:3], op=instr[2:0].
- op 000 NOP; 001 ACTION; 010 JUMP; 011 WAIT; 100 GAME; 101–111 illegal → FAULT.
- ACTION: func 00 move (act_target=i_num[4:0]), 01 get, 10 put (throw if i_sign[2]=1), 11 interact. act_cmd pulses exactly one cycle, then ACT_WAIT until feedback_sig=1; pc += PC_STEP.
- JUMP: func 00 always, 01 if feedback_sig=1, 10 if feedback_sig=0, 11 illegal. Taken: pc = pc + i_num (i_sign[0]=0) or pc − i_num (i_sign[0]=1), modulo 2^PC_W. Not taken: pc += PC_STEP. feedback_sig sampled in EXEC.
- WAIT: func 00 wait i_num ms (i_num=0 completes immediately); 01 wait for feedback_sig=1; 10 wait for feedback_sig=0; 11 illegal. For 01/10, i_num = timeout in ms, 0 = none; timeout expiry → FAULT.
- GAME: func 00 game_state=i_num; 01 HALT; 10 game_state=0; 11 illegal.
- FSM: IDLE → FETCH → EXEC → {IDLE | ACT_WAIT | MS_WAIT | FB_WAIT | HALT | FAULT}; waits return to IDLE on completion.
- IDLE leaves when step_pulse=1 or auto_mode=1. step_pulse outside IDLE is ignored (not queued).
- HALT and FAULT are sticky until res; step_pulse/auto_mode ignored.
- pc wraps modulo 2^PC_W on increment.

## Timing
- Reset values: pc=0, act_cmd=0, act_target=0, game_state=0, busy=0, halted=0, fault=0, state IDLE, timer 0.
- step_pulse sampled at edge t: FETCH in cycle t+1, EXEC in t+2; NOP/JUMP/GAME update pc at the end of EXEC (visible t+3).
- act_cmd is asserted in the cycle after EXEC, for one cycle. feedback_sig is checked from the following cycle, so a stale high level is not taken as completion.
- MS wait: counts ms_tick pulses after EXEC; completes in the cycle after the i_num-th tick.
- busy=1 in every state except IDLE, HALT and FAULT.
- Auto mode: the next FETCH follows IDLE with no extra gap (one IDLE cycle between instructions).
- res mid-wait or mid-action aborts immediately. No act_cmd pulse occurs in the reset cycle.

## Structure
- Package `script_pkg`: opcode constants (OP_NOP..OP_GAME), func codes, field bit positions, state enum, act_cmd bit indices.
- One sub-module `ms_countdown`: load value (MS_W), ms_tick decrement, zero flag. Shared by MS_WAIT duration and FB_WAIT timeout.

## Test plan
- Step mode, NOPs at 0,2,4 with three step_pulses → pc 2,4,6. A step_pulse while busy does not advance pc.
- ACTION move to target 5 (instr 0x0501) → act_cmd=10000 for one cycle with act_target=5. busy stays high until feedback_sig rises, then pc=2.
- JUMP conditional back 4 from pc=8 (i_sign[0]=1, func 01): with feedback=1 → pc=4; with feedback=0 → pc=10.
- WAIT 3 ms → busy for exactly 3 ms_ticks then pc advances. WAIT for feedback with timeout 2 and no feedback → fault=1 after the 2nd tick, sticky until res.
- GAME set 0x2A then GAME halt in auto mode → game_state=0x2A, halted=1, pc frozen.
- Illegal op 111 → fault=1. res asserted mid-MS_WAIT → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/script_pkg.sv
// Shared definitions for the script sequencer: instruction fields,
// opcode and func codes, FSM states and act_cmd bit positions.
package script_pkg;

    localparam int NUM_HI  = 15;
    localparam int NUM_LO  = 8;
    localparam int SIGN_HI = 7;
    localparam int SIGN_LO = 5;
    localparam int FUNC_HI = 4;
    localparam int FUNC_LO = 3;
    localparam int OP_HI   = 2;
    localparam int OP_LO   = 0;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ACTION = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_WAIT   = 3'b011;
    localparam logic [2:0] OP_GAME   = 3'b100;

    localparam logic [1:0] F_ACT_MOVE     = 2'b00;
    localparam logic [1:0] F_ACT_GET      = 2'b01;
    localparam logic [1:0] F_ACT_PUT      = 2'b10;
    localparam logic [1:0] F_ACT_INTERACT = 2'b11;

    localparam logic [1:0] F_JMP_ALWAYS = 2'b00;
    localparam logic [1:0] F_JMP_FB1    = 2'b01;
    localparam logic [1:0] F_JMP_FB0    = 2'b10;

    localparam logic [1:0] F_WAIT_MS  = 2'b00;
    localparam logic [1:0] F_WAIT_FB1 = 2'b01;
    localparam logic [1:0] F_WAIT_FB0 = 2'b10;

    localparam logic [1:0] F_GAME_SET  = 2'b00;
    localparam logic [1:0] F_GAME_HALT = 2'b01;
    localparam logic [1:0] F_GAME_CLR  = 2'b10;

    localparam int ACT_MOVE     = 4;
    localparam int ACT_GET      = 3;
    localparam int ACT_PUT      = 2;
    localparam int ACT_INTERACT = 1;
    localparam int ACT_THROW    = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_ACT_WAIT,
        S_MS_WAIT,
        S_FB_WAIT,
        S_HALT,
        S_FAULT
    } state_e;

    typedef struct packed {
        logic [7:0] num;
        logic [2:0] sign;
        logic [1:0] func;
        logic [2:0] op;
    } instr_t;

    function automatic instr_t decode(input logic [15:0] w);
        instr_t r;
        r.num  = w[NUM_HI:NUM_LO];
        r.sign = w[SIGN_HI:SIGN_LO];
        r.func = w[FUNC_HI:FUNC_LO];
        r.op   = w[OP_HI:OP_LO];
        return r;
    endfunction

endpackage

// File: rtl/ms_countdown.sv
// Millisecond down-counter: loads a value, decrements on each ms tick
// and saturates at zero. Used for both wait durations and timeouts.
module ms_countdown #(
    parameter int MS_W = 16
) (
    input  logic            clk,
    input  logic            res,
    input  logic            load_i,
    input  logic [MS_W-1:0] load_val_i,
    input  logic            tick_i,
    output logic            zero_o
);

    logic [MS_W-1:0] cnt_q;
    logic [MS_W-1:0] cnt_d;

    // Load has priority; ticks only count down while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/script_sequencer.sv
// Script sequencer: fetches and executes 16-bit script words
// (action, jump, wait, game-state) under a single control FSM.
module script_sequencer
    import script_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int PC_STEP = 2,
    parameter int MS_W    = 16
) (
    input  logic            clk,
    input  logic            res,
    input  logic [15:0]     instr,
    input  logic            step_pulse,
    input  logic            auto_mode,
    input  logic            ms_tick,
    input  logic            feedback_sig,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      act_cmd,
    output logic [4:0]      act_target,
    output logic [7:0]      game_state,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      gs_q, gs_d;
    logic [4:0]      act_cmd_q, act_cmd_d;
    logic [4:0]      act_tgt_q, act_tgt_d;
    logic            fb_pol_q, fb_pol_d;
    logic            tmo_en_q, tmo_en_d;

    logic            cd_load;
    logic [MS_W-1:0] cd_val;
    logic            cd_zero;

    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_jmp;
    logic [PC_W-1:0] off;
    instr_t          d;
    logic            unused_sign;

    assign d           = decode(instr);
    assign unused_sign = d.sign[1];
    assign off         = PC_W'(d.num);
    assign pc_next     = pc_q + PC_W'(PC_STEP);
    assign pc_jmp      = d.sign[0] ? (pc_q - off) : (pc_q + off);

    ms_countdown #(
        .MS_W(MS_W)
    ) u_cd (
        .clk       (clk),
        .res       (res),
        .load_i    (cd_load),
        .load_val_i(cd_val),
        .tick_i    (ms_tick),
        .zero_o    (cd_zero)
    );

    // Next-state, decode and execute logic of the control FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        gs_d      = gs_q;
        act_cmd_d = '0;
        act_tgt_d = act_tgt_q;
        fb_pol_d  = fb_pol_q;
        tmo_en_d  = tmo_en_q;
        cd_load   = 1'b0;
        cd_val    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (step_pulse || auto_mode) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_IDLE;
                case (d.op)
                    OP_NOP: pc_d = pc_next;
                    OP_ACTION: begin
                        state_d = S_ACT_WAIT;
                        case (d.func)
                            F_ACT_MOVE: begin
                                act_cmd_d[ACT_MOVE] = 1'b1;
                                act_tgt_d = d.num[4:0];
                            end
                            F_ACT_GET: act_cmd_d[ACT_GET] = 1'b1;
                            F_ACT_PUT: begin
                                if (d.sign[2]) act_cmd_d[ACT_THROW] = 1'b1;
                                else           act_cmd_d[ACT_PUT]   = 1'b1;
                            end
                            F_ACT_INTERACT: act_cmd_d[ACT_INTERACT] = 1'b1;
                        endcase
                    end
                    OP_JUMP: begin
                        case (d.func)
                            F_JMP_ALWAYS: pc_d = pc_jmp;
                            F_JMP_FB1: pc_d = feedback_sig ? pc_jmp : pc_next;
                            F_JMP_FB0: pc_d = feedback_sig ? pc_next : pc_jmp;
                            default: state_d = S_FAULT;
                        endcase
                    end
                    OP_WAIT: begin
                        cd_load = 1'b1;
                        cd_val  = MS_W'(d.num);
                        case (d.func)
                            F_WAIT_MS: begin
                                if (d.num == 8'd0) pc_d = pc_next;
                                else               state_d = S_MS_WAIT;
                            end
                            F_WAIT_FB1: begin
                                fb_pol_d = 1'b1;
                                tmo_en_d = (d.num != 8'd0);
                                state_d  = S_FB_WAIT;
                            end
                            F_WAIT_FB0: begin
                                fb_pol_d = 1'b0;
                                tmo_en_d = (d.num != 8'd0);
                                state_d  = S_FB_WAIT;
                            end
                            default: state_d = S_FAULT;
                        endcase
                    end
                    OP_GAME: begin
                        case (d.func)
                            F_GAME_SET: begin
                                gs_d = d.num;
                                pc_d = pc_next;
                            end
                            F_GAME_HALT: state_d = S_HALT;
                            F_GAME_CLR: begin
                                gs_d = 8'd0;
                                pc_d = pc_next;
                            end
                            default: state_d = S_FAULT;
                        endcase
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_ACT_WAIT: begin
                // The pulse cycle itself ignores feedback (stale level).
                if ((act_cmd_q == '0) && feedback_sig) begin
                    state_d = S_IDLE;
                    pc_d    = pc_next;
                end
            end
            S_MS_WAIT: begin
                if (cd_zero) begin
                    state_d = S_IDLE;
                    pc_d    = pc_next;
                end
            end
            S_FB_WAIT: begin
                if (feedback_sig == fb_pol_q) begin
                    state_d = S_IDLE;
                    pc_d    = pc_next;
                end else if (tmo_en_q && cd_zero) begin
                    state_d = S_FAULT;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
        endcase
    end

    // State and architectural registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            gs_q      <= '0;
            act_cmd_q <= '0;
            act_tgt_q <= '0;
            fb_pol_q  <= 1'b0;
            tmo_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            gs_q      <= gs_d;
            act_cmd_q <= act_cmd_d;
            act_tgt_q <= act_tgt_d;
            fb_pol_q  <= fb_pol_d;
            tmo_en_q  <= tmo_en_d;
        end
    end

    assign pc         = pc_q;
    assign act_cmd    = act_cmd_q;
    assign act_target = act_tgt_q;
    assign game_state = gs_q;
    assign busy       = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_script_sequencer.sv
// Testbench for script_sequencer: directed scenarios plus random
// single-step programs checked against an instruction-level model.
module tb_script_sequencer;

    logic        clk = 1'b0;
    logic        res;
    logic [15:0] instr;
    logic        step_pulse;
    logic        auto_mode;
    logic        ms_tick;
    logic        feedback_sig;
    logic [7:0]  pc;
    logic [4:0]  act_cmd;
    logic [4:0]  act_target;
    logic [7:0]  game_state;
    logic        busy;
    logic        halted;
    logic        fault;

    logic [15:0] rom [256];

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_pc;
    logic [7:0]  m_gs;
    logic [4:0]  m_tgt;

    logic [7:0]  r_n;
    logic [2:0]  r_sg;
    logic [1:0]  r_fn;
    logic [2:0]  r_op;
    int          cat;
    int          lim;

    script_sequencer #(
        .PC_W   (8),
        .PC_STEP(2),
        .MS_W   (16)
    ) dut (
        .clk         (clk),
        .res         (res),
        .instr       (instr),
        .step_pulse  (step_pulse),
        .auto_mode   (auto_mode),
        .ms_tick     (ms_tick),
        .feedback_sig(feedback_sig),
        .pc          (pc),
        .act_cmd     (act_cmd),
        .act_target  (act_target),
        .game_state  (game_state),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Registered script ROM: word at pc appears one cycle later.
    always @(posedge clk) instr <= rom[pc];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        res          = 1'b1;
        step_pulse   = 1'b0;
        auto_mode    = 1'b0;
        ms_tick      = 1'b0;
        feedback_sig = 1'b0;
        tick;
        tick;
        res   = 1'b0;
        m_pc  = 8'd0;
        m_gs  = 8'd0;
        m_tgt = 5'd0;
    endtask

    // Execute one instruction in step mode and compare with the model.
    task automatic run_step(input logic [15:0] w, input logic fb);
        logic [7:0] n  = w[15:8];
        logic [2:0] sg = w[7:5];
        logic [1:0] fn = w[4:3];
        logic [2:0] op = w[2:0];
        int         pulses = 0;
        logic [4:0] seen = 5'd0;
        logic [4:0] exp_cmd = 5'd0;
        int         cyc = 0;
        logic       done = 1'b0;
        logic       taken;
        rom[m_pc]    = w;
        feedback_sig = fb;
        step_pulse   = 1'b1;
        tick;
        step_pulse = 1'b0;
        while (!done && cyc < 300) begin
            ms_tick = (cyc % 3 == 2);
            tick;
            ms_tick = 1'b0;
            cyc++;
            if (act_cmd != 5'd0) begin
                pulses++;
                seen = act_cmd;
                feedback_sig = 1'b1;
            end
            if (!busy) done = 1'b1;
        end
        check("step_done", done, 1);
        case (op)
            3'd1: begin
                case (fn)
                    2'd0: exp_cmd = 5'b10000;
                    2'd1: exp_cmd = 5'b01000;
                    2'd2: exp_cmd = sg[2] ? 5'b00001 : 5'b00100;
                    default: exp_cmd = 5'b00010;
                endcase
                if (fn == 2'd0) m_tgt = n[4:0];
                m_pc = m_pc + 8'd2;
            end
            3'd2: begin
                taken = (fn == 2'd0) || (fn == 2'd1 && fb) ||
                        (fn == 2'd2 && !fb);
                if (!taken)     m_pc = m_pc + 8'd2;
                else if (sg[0]) m_pc = m_pc - n;
                else            m_pc = m_pc + n;
            end
            3'd4: begin
                if (fn == 2'd0) m_gs = n;
                if (fn == 2'd2) m_gs = 8'd0;
                m_pc = m_pc + 8'd2;
            end
            default: m_pc = m_pc + 8'd2;
        endcase
        check("step_pc", pc, m_pc);
        check("step_gs", game_state, m_gs);
        check("step_tgt", act_target, m_tgt);
        check("step_pulses", pulses, (op == 3'd1) ? 1 : 0);
        if (op == 3'd1) check("step_cmd", seen, exp_cmd);
        check("step_flags", {halted, fault}, 2'b00);
        feedback_sig = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

        // Reset values
        do_reset;
        check("rst_pc", pc, 0);
        check("rst_act", act_cmd, 0);
        check("rst_tgt", act_target, 0);
        check("rst_gs", game_state, 0);
        check("rst_busy", busy, 0);
        check("rst_halt", halted, 0);
        check("rst_fault", fault, 0);

        // NOP stepping
        run_step(16'h0000, 1'b0);
        check("nop_pc1", pc, 2);
        run_step(16'h0000, 1'b0);
        check("nop_pc2", pc, 4);
        run_step(16'h0000, 1'b0);
        check("nop_pc3", pc, 6);

        // ACTION move to target 5
        do_reset;
        rom[0] = 16'h0501;
        step_pulse = 1'b1;
        tick;
        step_pulse = 1'b0;
        check("act_fetch_busy", busy, 1);
        tick;
        check("act_exec_cmd", act_cmd, 0);
        tick;
        check("act_cmd", act_cmd, 5'b10000);
        check("act_tgt", act_target, 5);
        check("act_busy", busy, 1);
        step_pulse = 1'b1;
        tick;
        step_pulse = 1'b0;
        check("act_cmd_once", act_cmd, 0);
        repeat (3) tick;
        check("act_wait_busy", busy, 1);
        check("act_wait_pc", pc, 0);
        feedback_sig = 1'b1;
        tick;
        check("act_done_busy", busy, 0);
        check("act_done_pc", pc, 2);
        feedback_sig = 1'b0;
        repeat (3) tick;
        check("act_noqueue_pc", pc, 2);

        // Conditional backward jump from pc 8
        do_reset;
        repeat (4) run_step(16'h0000, 1'b0);
        check("jmp_start", pc, 8);
        run_step(16'h042A, 1'b1);
        check("jmp_taken", pc, 4);
        repeat (2) run_step(16'h0000, 1'b0);
        run_step(16'h042A, 1'b0);
        check("jmp_not_taken", pc, 10);

        // WAIT 3 ms
        do_reset;
        rom[0] = 16'h0303;
        step_pulse = 1'b1;
        tick;
        step_pulse = 1'b0;
        tick;
        tick;
        for (int k = 1; k <= 3; k++) begin
            ms_tick = 1'b1;
            tick;
            ms_tick = 1'b0;
            check("msw_busy", busy, 1);
            check("msw_pc", pc, 0);
            if (k < 3) begin
                tick;
                check("msw_gap_busy", busy, 1);
            end
        end
        tick;
        check("msw_done_busy", busy, 0);
        check("msw_done_pc", pc, 2);

        // WAIT for feedback with 2 ms timeout, no feedback
        do_reset;
        rom[0] = 16'h020B;
        step_pulse = 1'b1;
        tick;
        step_pulse = 1'b0;
        tick;
        tick;
        ms_tick = 1'b1;
        tick;
        ms_tick = 1'b0;
        check("tmo_t1_fault", fault, 0);
        check("tmo_t1_busy", busy, 1);
        tick;
        ms_tick = 1'b1;
        tick;
        ms_tick = 1'b0;
        tick;
        check("tmo_fault", fault, 1);
        check("tmo_busy", busy, 0);
        step_pulse = 1'b1;
        auto_mode  = 1'b1;
        feedback_sig = 1'b1;
        repeat (5) tick;
        step_pulse = 1'b0;
        auto_mode  = 1'b0;
        check("tmo_sticky", fault, 1);
        check("tmo_pc", pc, 0);
        do_reset;
        check("tmo_cleared", fault, 0);

        // GAME set then HALT in auto mode
        do_reset;
        rom[0] = 16'h2A04;
        rom[2] = 16'h000C;
        auto_mode = 1'b1;
        lim = 0;
        while (!halted && lim < 50) begin
            tick;
            lim++;
        end
        check("halt_reached", halted, 1);
        check("halt_gs", game_state, 8'h2A);
        check("halt_pc", pc, 2);
        check("halt_busy", busy, 0);
        step_pulse = 1'b1;
        repeat (5) tick;
        step_pulse = 1'b0;
        auto_mode  = 1'b0;
        check("halt_pc_frozen", pc, 2);
        check("halt_sticky", halted, 1);

        // Illegal opcode 111
        do_reset;
        rom[0] = 16'h0007;
        step_pulse = 1'b1;
        tick;
        step_pulse = 1'b0;
        repeat (3) tick;
        check("ill_fault", fault, 1);
        check("ill_busy", busy, 0);
        check("ill_pc", pc, 0);

        // Reset in the middle of an MS wait
        do_reset;
        run_step(16'h5504, 1'b0);
        rom[2] = 16'h0A03;
        step_pulse = 1'b1;
        tick;
        step_pulse = 1'b0;
        tick;
        tick;
        check("mid_busy", busy, 1);
        res = 1'b1;
        tick;
        check("mid_pc", pc, 0);
        check("mid_gs", game_state, 0);
        check("mid_busy0", busy, 0);
        check("mid_act", act_cmd, 0);
        check("mid_flags", {halted, fault}, 2'b00);
        res = 1'b0;

        // Random single-step programs against the model
        do_reset;
        for (int s = 0; s < 40; s++) begin
            cat  = int'($urandom_range(0, 4));
            r_n  = 8'($urandom);
            r_sg = 3'($urandom);
            r_fn = 2'($urandom);
            case (cat)
                0: r_op = 3'd0;
                1: r_op = 3'd1;
                2: begin
                    r_op = 3'd2;
                    r_fn = 2'($urandom_range(0, 2));
                end
                3: begin
                    r_op = 3'd3;
                    r_fn = 2'd0;
                    r_n  = 8'($urandom_range(0, 3));
                end
                default: begin
                    r_op = 3'd4;
                    r_fn = 2'($urandom_range(0, 1) * 2);
                end
            endcase
            run_step({r_n, r_sg, r_fn, r_op}, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
